// File: rtl/mvau_out_pkg.sv
// -----------------------------------------------------------------------------
// mvau_out_pkg
// Shared definitions for the MVAU PE output stage: the default array geometry,
// the pointer-width helper used by the output FIFO, and the lane types at the
// default widths.
// -----------------------------------------------------------------------------
package mvau_out_pkg;

  localparam int PE_DEF       = 8;
  localparam int TDSTI_DEF    = 32;
  localparam int TO_DEF       = 16;
  localparam int DEPTH_DEF    = 8;
  localparam int STALL_TH_DEF = 3;

  typedef logic signed [TDSTI_DEF-1:0] acc_lane_t;
  typedef logic signed [TO_DEF-1:0]    out_lane_t;

  // Pointer width with one extra wrap bit, so that full and empty differ.
  function automatic int clog2p1(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mvu_out_fifo.sv
// -----------------------------------------------------------------------------
// mvu_out_fifo
// Generic synchronous FIFO, W bits wide and DEPTH words deep, with a registered
// read port. The head word is always held in the output register, so rd_v is
// high whenever the FIFO holds anything and fill counts that word as well.
//
// Ports
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset (pointers, valid and output data)
//   wr_en   in   write request; accepted when not full or when a read happens
//   wr_dat  in   W-bit write word
//   rd_rdy  in   consumer ready; a read happens when rd_v & rd_rdy
//   rd_v    out  head word valid
//   rd_dat  out  head word, stable while rd_v & ~rd_rdy
//   fill    out  occupancy, $clog2(DEPTH)+1 bits
//   full    out  DEPTH words queued
//   empty   out  no words queued
// -----------------------------------------------------------------------------
module mvu_out_fifo
  import mvau_out_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [W-1:0]                wr_dat,
  input  logic                        rd_rdy,
  output logic                        rd_v,
  output logic [W-1:0]                rd_dat,
  output logic [clog2p1(DEPTH)-1:0]   fill,
  output logic                        full,
  output logic                        empty
);

  localparam int PTR_W = clog2p1(DEPTH);
  localparam int IDX_W = PTR_W - 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_p1;
  logic [PTR_W-1:0] rd_ptr_p1;
  logic [PTR_W-1:0] wr_ptr_p0;
  logic [PTR_W-1:0] rd_ptr_p0;
  logic             wr_fire_p0;
  logic             rd_fire_p0;
  logic             vld_p0;
  logic             vld_p1;
  logic [W-1:0]     dat_p0;
  logic [W-1:0]     dat_p1;

  assign empty = (wr_ptr_p1 == rd_ptr_p1);
  assign full  = (wr_ptr_p1[IDX_W-1:0] == rd_ptr_p1[IDX_W-1:0]) &&
                 (wr_ptr_p1[IDX_W] != rd_ptr_p1[IDX_W]);
  assign fill  = wr_ptr_p1 - rd_ptr_p1;

  // ---- stage p0: handshake decode and next-state ----
  always_comb begin
    rd_fire_p0 = vld_p1 & rd_rdy;
    wr_fire_p0 = wr_en & (~full | rd_fire_p0);
    wr_ptr_p0  = wr_ptr_p1 + {{(PTR_W-1){1'b0}}, wr_fire_p0};
    rd_ptr_p0  = rd_ptr_p1 + {{(PTR_W-1){1'b0}}, rd_fire_p0};
    vld_p0     = (wr_ptr_p0 != rd_ptr_p0);
    dat_p0     = dat_p1;
    if (rd_ptr_p0 == wr_ptr_p1) begin
      // The new head is the slot being written this cycle (or nothing):
      // bypass the incoming word, otherwise hold the last value.
      if (wr_fire_p0) begin
        dat_p0 = wr_dat;
      end
    end else begin
      dat_p0 = mem[rd_ptr_p0[IDX_W-1:0]];
    end
  end

  // ---- stage p1: storage, pointers and output register ----
  always_ff @(posedge clk) begin
    if (wr_fire_p0) begin
      mem[wr_ptr_p1[IDX_W-1:0]] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
      vld_p1    <= 1'b0;
      dat_p1    <= '0;
    end else begin
      wr_ptr_p1 <= wr_ptr_p0;
      rd_ptr_p1 <= rd_ptr_p0;
      vld_p1    <= vld_p0;
      dat_p1    <= dat_p0;
    end
  end

  assign rd_v   = vld_p1;
  assign rd_dat = dat_p1;

endmodule

// File: rtl/mvu_pe_out_buf.sv
// -----------------------------------------------------------------------------
// mvu_pe_out_buf
// Output stage behind the PE accumulators of the MVAU stream datapath. Each
// accumulator-valid pulse captures all PE lanes, narrows every lane from TDstI
// to TO bits, and queues the word in a small FIFO presented as a ready/valid
// stream. An almost-full stall tells MVAU control to stop issuing results early
// enough that the accumulator pipeline can still drain into the queue.
//
// Build option
//   MVU_OUT_SAT_EN  defined: lanes saturate to the signed TO range
//                   undefined: lanes keep their TO LSBs (wrap-around)
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   in_acc_v  in   accumulator result valid (single-cycle pulse per result)
//   in_acc    in   PE*TDstI, lane p = in_acc[p*TDstI +: TDstI], signed
//   out_v     out  output word valid
//   out_rdy   in   downstream ready
//   out_dat   out  PE*TO, lane p = out_dat[p*TO +: TO], signed
//   stall     out  registered almost-full back-pressure
//   ovf_err   out  sticky: a result arrived while full and was dropped
//   fill      out  queued words, including the one on out_dat
// -----------------------------------------------------------------------------
module mvu_pe_out_buf
  import mvau_out_pkg::*;
#(
  parameter int PE       = PE_DEF,
  parameter int TDstI    = TDSTI_DEF,
  parameter int TO       = TO_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int STALL_TH = STALL_TH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_acc_v,
  input  logic [PE*TDstI-1:0]         in_acc,
  output logic                        out_v,
  input  logic                        out_rdy,
  output logic [PE*TO-1:0]            out_dat,
  output logic                        stall,
  output logic                        ovf_err,
  output logic [clog2p1(DEPTH)-1:0]   fill
);

  localparam int PTR_W = clog2p1(DEPTH);

`ifdef MVU_OUT_SAT_EN
  localparam logic signed [TDstI-1:0] SAT_MAX = {{(TDstI-TO+1){1'b0}}, {(TO-1){1'b1}}};
  localparam logic signed [TDstI-1:0] SAT_MIN = {{(TDstI-TO+1){1'b1}}, {(TO-1){1'b0}}};

  function automatic logic signed [TO-1:0] narrow_lane(input logic signed [TDstI-1:0] a);
    if (a > SAT_MAX) begin
      return SAT_MAX[TO-1:0];
    end else if (a < SAT_MIN) begin
      return SAT_MIN[TO-1:0];
    end
    return a[TO-1:0];
  endfunction
`else
  // Two's complement wrap: keep the TO LSBs (identity when TO == TDstI).
  function automatic logic signed [TO-1:0] narrow_lane(input logic signed [TDstI-1:0] a);
    return a[TO-1:0];
  endfunction
`endif

  logic [PE*TO-1:0]  wr_dat_p0;
  logic              push_p0;
  logic              pop_p0;
  logic [PTR_W-1:0]  fill_p0;
  logic              stall_p0;
  logic              ovf_p0;
  logic              stall_p1;
  logic              ovf_p1;
  logic              fifo_full;
  logic              fifo_empty;

  // ---- stage p0: lane narrowing, handshake and control next-state ----
  always_comb begin
    wr_dat_p0 = '0;
    for (int p = 0; p < PE; p++) begin
      wr_dat_p0[p*TO +: TO] = narrow_lane(in_acc[p*TDstI +: TDstI]);
    end
  end

  always_comb begin
    pop_p0   = ~fifo_empty & out_rdy;
    push_p0  = in_acc_v & (~fifo_full | pop_p0);
    fill_p0  = fill + {{(PTR_W-1){1'b0}}, push_p0} - {{(PTR_W-1){1'b0}}, pop_p0};
    stall_p0 = (int'(fill_p0) >= DEPTH - STALL_TH);
    ovf_p0   = ovf_p1 | (in_acc_v & fifo_full & ~pop_p0);
  end

  // ---- stage p1: queue with registered head, stall and overflow flags ----
  mvu_out_fifo #(
    .W     (PE*TO),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (push_p0),
    .wr_dat (wr_dat_p0),
    .rd_rdy (out_rdy),
    .rd_v   (out_v),
    .rd_dat (out_dat),
    .fill   (fill),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_p1 <= 1'b0;
      ovf_p1   <= 1'b0;
    end else begin
      stall_p1 <= stall_p0;
      ovf_p1   <= ovf_p0;
    end
  end

  assign stall   = stall_p1;
  assign ovf_err = ovf_p1;

endmodule
